down_count_seq: RTL and testbench

DOWN_COUNT_SEQ -- requirements
Module: down_count_seq

---
 rtl/down_count_pkg.sv | 17 +
 rtl/down_count_core.sv | 48 ++++
 rtl/down_count_seq.sv | 146 ++++++++++++++
 tb/tb_down_count_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_count_pkg.sv
// -----------------------------------------------------------------------------
// down_count_pkg
// Shared definitions for the down_count_seq block.
//   state_e       : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   DEFAULT_WIDTH : default bit width of the load value and the count
// -----------------------------------------------------------------------------
package down_count_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : down_count_pkg

// File: rtl/down_count_core.sv
// -----------------------------------------------------------------------------
// down_count_core
// WIDTH-bit count register with synchronous load, decrement enable and a
// combinational zero flag. Sequencing is left to the instantiating FSM.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, clears the count
//   i_load     : load i_load_val (priority over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement by one; saturates at zero
//   o_count    : current registered count
//   o_zero     : (o_count == 0), same cycle
// -----------------------------------------------------------------------------
module down_count_core
  import down_count_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;
  logic             w_zero;

  assign w_zero = (r_count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && !w_zero) begin
      // Guarded so the register can never wrap below zero.
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = w_zero;

endmodule : down_count_core

// File: rtl/down_count_seq.sv
// -----------------------------------------------------------------------------
// down_count_seq
// Loadable down counter sequenced by an IDLE/RUN/DONE FSM. A start in IDLE
// loads load_val; the count decrements in RUN while cnt_en is high and DONE
// is entered as the count reaches zero. abort returns to IDLE holding the
// count; rst clears everything and wins over every other input.
//
// Configuration macro:
//   DOWN_COUNT_SEQ_AUTORELOAD_EN : when defined, DONE reloads the count from
//   the value captured at start and returns to RUN, giving a periodic done.
//   A captured value of zero keeps the FSM in DONE (done every cycle).
//   When undefined, DONE always returns to IDLE.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : load load_val and begin counting (accepted only when ready)
//   load_val : initial count
//   cnt_en   : decrement enable in RUN; low pauses the count
//   abort    : return to IDLE, count held
//   ready    : state is IDLE
//   busy     : state is RUN
//   done     : state is DONE
//   zero     : count == 0, no lag
//   count    : current registered count
// -----------------------------------------------------------------------------
module down_count_seq
  import down_count_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cnt_en,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic [WIDTH-1:0] count
);

  state_e           r_state;
  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic             w_dec;
  logic             w_last;
  logic [WIDTH-1:0] w_count;
  logic             w_zero;

`ifdef DOWN_COUNT_SEQ_AUTORELOAD_EN
  logic [WIDTH-1:0] r_reload;
  logic             w_reload;
`endif

  // ---------------------------------------------------------------------------
  // Datapath controls, derived from the state register and the inputs.
  // ---------------------------------------------------------------------------
  assign w_accept = (r_state == IDLE) && start && !abort;
  assign w_dec    = (r_state == RUN) && cnt_en && !abort;
  assign w_last   = (w_count == WIDTH'(1));

`ifdef DOWN_COUNT_SEQ_AUTORELOAD_EN
  // A zero reload value leaves the FSM parked in DONE with the count at 0.
  assign w_reload   = (r_state == DONE) && !abort && (r_reload != '0);
  assign w_load     = w_accept || w_reload;
  assign w_load_val = w_accept ? load_val : r_reload;
`else
  assign w_load     = w_accept;
  assign w_load_val = load_val;
`endif

  down_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
`ifdef DOWN_COUNT_SEQ_AUTORELOAD_EN
      r_reload <= '0;
`endif
    end else if (abort) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= (load_val == '0) ? DONE : RUN;
`ifdef DOWN_COUNT_SEQ_AUTORELOAD_EN
            r_reload <= load_val;
`endif
          end
        end
        RUN: begin
          if (cnt_en && w_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
`ifdef DOWN_COUNT_SEQ_AUTORELOAD_EN
          if (r_reload != '0) begin
            r_state <= RUN;
          end
`else
          r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Status flags decode the state register alone, so they are glitch-free
  // and mutually exclusive by construction.
  assign ready = (r_state == IDLE);
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign zero  = w_zero;
  assign count = w_count;

  // ---------------------------------------------------------------------------
  // Assertions
  // ---------------------------------------------------------------------------
  a_onehot_status : assert property (@(posedge clk) disable iff (rst)
    $onehot({ready, busy, done}));

  // Outside RUN the count only changes through a load.
  a_hold_outside_run : assert property (@(posedge clk) disable iff (rst)
    ((r_state != RUN) && !w_load) |=> (count == $past(count)));

endmodule : down_count_seq

// File: tb/tb_down_count_seq.sv
module tb_down_count_seq;

`ifdef DOWN_COUNT_SEQ_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // Flag nibble order: {ready, busy, done, zero}
  localparam logic [3:0] F_IDLE0 = 4'b1001;
  localparam logic [3:0] F_IDLE  = 4'b1000;
  localparam logic [3:0] F_RUN   = 4'b0100;
  localparam logic [3:0] F_DONE  = 4'b0011;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] load_val;
  logic        cnt_en;
  logic        abort;

  logic        ready8, busy8, done8, zero8;
  logic [7:0]  count8;
  logic        ready12, busy12, done12, zero12;
  logic [11:0] count12;

  logic [11:0] st8;
  logic [15:0] st12;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  down_count_seq #(
    .WIDTH (8)
  ) dut8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_val (load_val[7:0]),
    .cnt_en   (cnt_en),
    .abort    (abort),
    .ready    (ready8),
    .busy     (busy8),
    .done     (done8),
    .zero     (zero8),
    .count    (count8)
  );

  down_count_seq #(
    .WIDTH (12)
  ) dut12 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_val (load_val),
    .cnt_en   (cnt_en),
    .abort    (abort),
    .ready    (ready12),
    .busy     (busy12),
    .done     (done12),
    .zero     (zero12),
    .count    (count12)
  );

  assign st8  = {ready8, busy8, done8, zero8, count8};
  assign st12 = {ready12, busy12, done12, zero12, count12};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    abort = 1'b1;
    start = 1'b0;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; load_val = '0; cnt_en = 1'b0; abort = 1'b0;
    tick();
    tick();
    total++;
    if (st8 !== {F_IDLE0, 8'd0}) begin
      $display("FAIL reset8 got=%h want=%h", st8, {F_IDLE0, 8'd0}); bad++;
    end
    total++;
    if (st12 !== {F_IDLE0, 12'd0}) begin
      $display("FAIL reset12 got=%h want=%h", st12, {F_IDLE0, 12'd0}); bad++;
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [11:0] exp;
    start = 1'b1; load_val = 12'd5; cnt_en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp = {F_RUN, 8'(5 - i)};
      total++;
      if (st8 !== exp) begin
        $display("FAIL basic_run%0d got=%h want=%h", i, st8, exp); bad++;
      end
      tick();
    end
    total++;
    if (st8 !== {F_DONE, 8'd0}) begin
      $display("FAIL basic_done got=%h want=%h", st8, {F_DONE, 8'd0}); bad++;
    end
    tick();
    exp = AUTO ? {F_RUN, 8'd5} : {F_IDLE0, 8'd0};
    total++;
    if (st8 !== exp) begin
      $display("FAIL basic_after got=%h want=%h", st8, exp); bad++;
    end
    go_idle();
  endtask

  task automatic test_zero_load();
    logic [11:0] exp;
    start = 1'b1; load_val = 12'd0; cnt_en = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (st8 !== {F_DONE, 8'd0}) begin
      $display("FAIL zero_done got=%h want=%h", st8, {F_DONE, 8'd0}); bad++;
    end
    tick();
    exp = AUTO ? {F_DONE, 8'd0} : {F_IDLE0, 8'd0};
    total++;
    if (st8 !== exp) begin
      $display("FAIL zero_after got=%h want=%h", st8, exp); bad++;
    end
    go_idle();
  endtask

  task automatic test_pause();
    start = 1'b1; load_val = 12'd3; cnt_en = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (st8 !== {F_RUN, 8'd3}) begin
      $display("FAIL pause_c1 got=%h want=%h", st8, {F_RUN, 8'd3}); bad++;
    end
    tick();
    cnt_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (st8 !== {F_RUN, 8'd2}) begin
        $display("FAIL pause_hold%0d got=%h want=%h", i, st8, {F_RUN, 8'd2}); bad++;
      end
      tick();
    end
    cnt_en = 1'b1;
    total++;
    if (st8 !== {F_RUN, 8'd2}) begin
      $display("FAIL pause_c6 got=%h want=%h", st8, {F_RUN, 8'd2}); bad++;
    end
    tick();
    total++;
    if (st8 !== {F_RUN, 8'd1}) begin
      $display("FAIL pause_c7 got=%h want=%h", st8, {F_RUN, 8'd1}); bad++;
    end
    tick();
    total++;
    if (st8 !== {F_DONE, 8'd0}) begin
      $display("FAIL pause_c8 got=%h want=%h", st8, {F_DONE, 8'd0}); bad++;
    end
    go_idle();
  endtask

  task automatic test_abort();
    start = 1'b1; load_val = 12'd200; cnt_en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 193; i++) tick();
    total++;
    if (st8 !== {F_RUN, 8'd7}) begin
      $display("FAIL abort_pre got=%h want=%h", st8, {F_RUN, 8'd7}); bad++;
    end
    abort = 1'b1; start = 1'b1; load_val = 12'd50;
    tick();
    abort = 1'b0; start = 1'b0;
    total++;
    if (st8 !== {F_IDLE, 8'd7}) begin
      $display("FAIL abort_idle got=%h want=%h", st8, {F_IDLE, 8'd7}); bad++;
    end
    tick();
    total++;
    if (st8 !== {F_IDLE, 8'd7}) begin
      $display("FAIL abort_noqueue got=%h want=%h", st8, {F_IDLE, 8'd7}); bad++;
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    start = 1'b1; load_val = 12'd4; cnt_en = 1'b1;
    tick();
    load_val = 12'd9;   // start stays high; must be ignored outside IDLE
    for (int i = 0; i < 4; i++) begin
      exp = {F_RUN, 8'(4 - i)};
      total++;
      if (st8 !== exp) begin
        $display("FAIL b2b_run%0d got=%h want=%h", i, st8, exp); bad++;
      end
      tick();
    end
    total++;
    if (st8 !== {F_DONE, 8'd0}) begin
      $display("FAIL b2b_done got=%h want=%h", st8, {F_DONE, 8'd0}); bad++;
    end
    tick();
    exp = AUTO ? {F_RUN, 8'd4} : {F_IDLE0, 8'd0};
    total++;
    if (st8 !== exp) begin
      $display("FAIL b2b_after got=%h want=%h", st8, exp); bad++;
    end
    tick();
    exp = AUTO ? {F_RUN, 8'd3} : {F_RUN, 8'd9};
    total++;
    if (st8 !== exp) begin
      $display("FAIL b2b_restart got=%h want=%h", st8, exp); bad++;
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; load_val = 12'd5; cnt_en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (st8 !== {F_RUN, 8'd3}) begin
      $display("FAIL rstmid_pre got=%h want=%h", st8, {F_RUN, 8'd3}); bad++;
    end
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    total++;
    if (st8 !== {F_IDLE0, 8'd0}) begin
      $display("FAIL rstmid_idle got=%h want=%h", st8, {F_IDLE0, 8'd0}); bad++;
    end
    tick();
    total++;
    if (st8 !== {F_IDLE0, 8'd0}) begin
      $display("FAIL rstmid_nodone got=%h want=%h", st8, {F_IDLE0, 8'd0}); bad++;
    end
    start = 1'b1; load_val = 12'd0;
    tick();
    total++;
    if (st8 !== {F_DONE, 8'd0}) begin
      $display("FAIL rstdone_pre got=%h want=%h", st8, {F_DONE, 8'd0}); bad++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    total++;
    if (st8 !== {F_IDLE0, 8'd0}) begin
      $display("FAIL rstdone_idle got=%h want=%h", st8, {F_IDLE0, 8'd0}); bad++;
    end
  endtask

  task automatic test_width12();
    int n;
    start = 1'b1; load_val = 12'd4095; cnt_en = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (st12 !== {F_RUN, 12'd4095}) begin
      $display("FAIL w12_load got=%h want=%h", st12, {F_RUN, 12'd4095}); bad++;
    end
    n = 1;
    while (!done12 && n < 5000) begin
      tick();
      n++;
    end
    total++;
    if (n != 4096) begin
      $display("FAIL w12_latency got=%0d want=4096", n); bad++;
    end
    total++;
    if (st12 !== {F_DONE, 12'd0}) begin
      $display("FAIL w12_done got=%h want=%h", st12, {F_DONE, 12'd0}); bad++;
    end
    go_idle();
  endtask

  task automatic test_autoreload();
    logic [11:0] exp;
    start = 1'b1; load_val = 12'd2; cnt_en = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (st8 !== {F_DONE, 8'd0}) begin
      $display("FAIL ar_done0 got=%h want=%h", st8, {F_DONE, 8'd0}); bad++;
    end
    for (int p = 0; p < 2; p++) begin
      tick();
      exp = AUTO ? {F_RUN, 8'd2} : {F_IDLE0, 8'd0};
      total++;
      if (st8 !== exp) begin
        $display("FAIL ar_p%0d_c1 got=%h want=%h", p, st8, exp); bad++;
      end
      tick();
      exp = AUTO ? {F_RUN, 8'd1} : {F_IDLE0, 8'd0};
      total++;
      if (st8 !== exp) begin
        $display("FAIL ar_p%0d_c2 got=%h want=%h", p, st8, exp); bad++;
      end
      tick();
      exp = AUTO ? {F_DONE, 8'd0} : {F_IDLE0, 8'd0};
      total++;
      if (st8 !== exp) begin
        $display("FAIL ar_p%0d_c3 got=%h want=%h", p, st8, exp); bad++;
      end
    end
    go_idle();
    total++;
    if ({ready8, busy8, done8} !== 3'b100) begin
      $display("FAIL ar_abort got=%b want=100", {ready8, busy8, done8}); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_load();
    test_pause();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_width12();
    test_autoreload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_down_count_seq
